// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: WIDTH+1 cycles start->valid (normal), 1 cycle for divide-by-zero / signed overflow.
// Backpressure: none downstream; start is only taken while ready=1, otherwise ignored.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dmag;
  logic             qsign;
  logic             rsign;
  logic             is_rem;

  // Acceptance-time decode of the incoming operands
  logic             is_signed;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] special_res;

  // One restoring step and the final result it would produce
  logic [WIDTH:0]   p_shift;
  logic             p_ge;
  logic [WIDTH:0]   p_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] calc_res;
  logic             last_iter;

  assign ready = (state == ST_IDLE);
  assign busy  = !ready;

  // Classify the request presented on the ports and form operand magnitudes.
  always_comb begin
    is_signed   = !op[0];
    div_zero    = (divisor == '0);
    sgn_ovf     = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    dvd_mag     = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dvs_mag     = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    special_res = '0;
    if (op[1]) begin
      special_res = div_zero ? dividend : '0;
    end else begin
      special_res = div_zero ? '1 : dividend;
    end
  end

  // Shift {P,Q} left by one and subtract the divisor magnitude when it fits.
  // P never exceeds the divisor before a shift, so its top bit only matters after one.
  always_comb begin
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    p_ge    = p[WIDTH] || (p_shift >= {1'b0, dmag});
    p_nxt   = p_shift;
    q_nxt   = {q[WIDTH-2:0], 1'b0};
    if (p_ge) begin
      p_nxt = p_shift - {1'b0, dmag};
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
    if (is_rem) begin
      calc_res = rsign ? (~p_nxt[WIDTH-1:0] + 1'b1) : p_nxt[WIDTH-1:0];
    end else begin
      calc_res = qsign ? (~q_nxt + 1'b1) : q_nxt;
    end
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM plus datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      p      <= '0;
      q      <= '0;
      dmag   <= '0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      is_rem <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            is_rem <= op[1];
            if (div_zero || sgn_ovf) begin
              result <= special_res;
              valid  <= 1'b1;
              state  <= ST_DONE;
            end else begin
              p     <= '0;
              q     <= dvd_mag;
              dmag  <= dvs_mag;
              qsign <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              rsign <= is_signed && dividend[WIDTH-1];
              cnt   <= '0;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          p   <= p_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            result <= calc_res;
            valid  <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          valid <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32).
// Inputs are driven on the falling edge, outputs sampled 1ns after the rising edge.
// Every expected value below is hand-computed from the RV32M definition.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble operands after acceptance, and check
  // latency, result, ready/busy during the op, and return to idle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int n;
    logic ready_seen;
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    ready_seen = 1'b0;
    while (!valid && n < 100) begin
      if (ready || !busy) ready_seen = 1'b1;
      dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      n++;
    end
    if (ready || !busy) ready_seen = 1'b1;
    chk({tag, " latency"}, W'(n), W'(lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " ready low while busy"}, W'(ready_seen), W'(0));
    @(posedge clk); #1;
    chk({tag, " valid one cycle"}, W'(valid), W'(0));
    chk({tag, " ready back"}, W'(ready), W'(1));
  endtask

  initial begin
    int nvalid;
    logic [W-1:0] held;
    logic stable;

    resetn = 1'b0; start = 1'b0; op = OP_DIV; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", W'(ready), W'(1));
    chk("reset busy", W'(busy), W'(0));
    chk("reset valid", W'(valid), W'(0));
    chk("reset result", result, '0);
    @(negedge clk); resetn = 1'b1;

    // Unsigned basics
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu ffffffff/16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);
    run_op("remu ffffffff/fffffffe", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);

    // Signed
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div min/1", OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 33);
    run_op("rem -100/7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);

    // Divide by zero and signed overflow finish early
    run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu 1234/0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu min/ffffffff", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // start held through CALC and DONE with changing operands: one valid only
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    nvalid = 0;
    for (int i = 0; i < 40 && nvalid == 0; i++) begin
      dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    chk("held start valid", W'(nvalid), W'(1));
    chk("held start result", result, 32'd100);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held start back to idle", W'(ready), W'(1));
    held = result;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
      if (valid) nvalid++;
      if (result !== held) stable = 1'b0;
    end
    chk("no second valid", W'(nvalid), W'(1));
    chk("result stable idle", W'(stable), W'(1));

    // Reset in the middle of CALC
    @(negedge clk);
    op = OP_DIVU; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("abort valid", W'(valid), W'(0));
    chk("abort result", result, '0);
    chk("abort ready", W'(ready), W'(1));
    chk("abort busy", W'(busy), W'(0));
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    chk("abort no valid", W'(nvalid), W'(0));
    run_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. Operands come from the register-file read ports; a one-cycle `valid` pulse and a held `result` go to the writeback result multiplexer. It handshakes with the control unit, which holds the core (PC enable low) while the divider is busy. One quotient bit is resolved per cycle. Divide-by-zero and signed-overflow cases finish early.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only on a posedge where `ready`=1
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`
- dividend  in  WIDTH  rs1 value; sampled with `start`
- divisor  in  WIDTH  rs2 value; sampled with `start`
- ready  out  1  high only in IDLE; combinational from state
- busy  out  1  high in CALC and DONE; equals `!ready`
- valid  out  1  registered; high for exactly one cycle (state DONE)
- result  out  WIDTH  registered; holds its last value until the next `valid`

## Operation
- States:
  - IDLE: `ready`=1. On `start`, latch the operands, go to CALC (normal case) or DONE (special case).
  - CALC: one iteration per cycle. After WIDTH iterations, go to DONE.
  - DONE: `valid`=1. Next edge always returns to IDLE.
- Start acceptance: `start` in CALC or DONE is ignored and has no side effects; it must be re-issued after `ready` returns.
- Special cases, decided at acceptance; the unit skips CALC:
  - Divisor = 0: quotient = all ones; remainder = dividend.
  - Signed op (DIV/REM), dividend = 1 followed by WIDTH-1 zeros, divisor = all ones: quotient = dividend; remainder = 0.
- Normal case, signed ops:
  - Use operand magnitudes (two's-complement negate if MSB=1). Magnitude of the most-negative value is representable as an unsigned value.
  - Register two flags: quotient sign = dividend MSB XOR divisor MSB; remainder sign = dividend MSB.
- Normal case, unsigned ops: operands are used unmodified and both sign flags are 0.
- Restoring iteration, MSB first, with a WIDTH+1-bit partial remainder P (reset to 0 at acceptance) and quotient/shift register Q (loaded with the magnitude dividend):
  - Shift {P,Q} left one bit.
  - If P ≥ divisor magnitude: P = P − divisor magnitude and Q[0]=1; otherwise Q[0]=0.
  - A 6-bit (clog2(WIDTH)+1) iteration counter counts 0..WIDTH-1. The CALC→DONE transition occurs on the edge that completes iteration WIDTH-1.
- Result selection, registered on the edge entering DONE:
  - DIV/DIVU: Q, negated if quotient sign is set.
  - REM/REMU: P[WIDTH-1:0], negated if remainder sign is set.
- Identities that must hold for every non-special case: dividend = quotient·divisor + remainder; |remainder| < |divisor|; remainder sign equals dividend sign (or remainder = 0).

## Timing
- Reset values: state IDLE, `valid`=0, `result`=0, counter=0, P=0, Q=0. Hence `ready`=1 and `busy`=0 in the cycle after the reset edge.
- Reset asserted in any state: the operation is aborted on that edge, no `valid` is produced, and `result` is cleared to 0.
- Edge numbering: edge 0 is the edge that accepts `start`.
- Normal case latency:
  - CALC occupies the cycles after edges 0..WIDTH-1.
  - DONE (`valid`=1, new `result`) is the cycle after edge WIDTH, i.e. WIDTH+1 cycles after `start` was presented (33 for WIDTH=32).
  - `ready`=1 again after edge WIDTH+1.
- Special case latency: DONE is the cycle after edge 0 (`valid` 1 cycle after `start`). `ready` returns after edge 1.
- Minimum start-to-start spacing: WIDTH+2 cycles (normal case), 2 cycles (special case).
- Operand independence: `dividend`, `divisor` and `op` may change freely after edge 0 without affecting the in-flight operation.

## Test plan
- DIVU 100 / 7 → `valid` exactly 33 cycles after `start`, `result`=14. Then REMU 100 / 7 → 2. `ready`=0 throughout both operations.
- Signed operations:
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - REM 7 / −2 → 1.
  - DIV 0x80000000 / 1 → 0x80000000.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF; REMU 0x1234 / 0 → 0x1234. Each must show `valid` 1 cycle after `start`.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Latency 1. DIVU with the same operands → 0 at normal latency (33 cycles).
- Protocol:
  - Hold `start`=1 and change the operands every cycle during CALC → exactly one `valid`, with the first operation's result.
  - Pulse `start` in the DONE cycle → ignored, no second `valid`.
  - `result` stays stable in IDLE.
- Reset: assert `resetn`=0 at iteration 10 → no `valid`, `result`=0, `ready`=1 in the cycle after the reset edge. Then a new DIVU 9 / 3 → 3.
